// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter and, later, the receiver.
//   - uart_state_e : frame state encoding (idle, start, data, parity, stop)
//   - PAR_*        : parity_mode encodings (2'b11 also means no parity)
//   - eff_div()    : maps a run-time baud_div onto the divisor actually used
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // 0 selects the default divisor; anything below 2 is raised to 2 so every
  // bit lasts at least two clock cycles.
  function automatic logic [31:0] eff_div(input logic [31:0] baud_div,
                                          input logic [31:0] def_div);
    logic [31:0] d;
    d = (baud_div == 32'd0) ? def_div : baud_div;
    if (d < 32'd2) begin
      d = 32'd2;
    end
    return d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: per-bit divisor counter.
// Counts 0..div_i-1 while enabled and pulses bit_done_o for one cycle on the
// last count of every bit, wrapping to 0.
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset
//   clear_i    : synchronous clear, forces the count back to 0
//   en_i       : count enable
//   div_i      : cycles per bit (expected >= 2)
//   bit_done_o : one-cycle pulse in the final cycle of each bit
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             bit_done_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             last;

  assign last       = (cnt_q == (div_i - DIV_W'(1)));
  assign bit_done_o = en_i && !clear_i && last;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter with valid/ready input handshake.
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
// Optional feature macro: UART_TX_PARITY_EN adds parity_mode_i and the parity bit.
//   clk_i         : clock, rising edge
//   rst_ni        : asynchronous active-low reset
//   tx_data_i     : word to send
//   tx_valid_i    : tx_data_i is valid
//   tx_ready_o    : block is idle and takes a word on the next edge with tx_valid_i
//   baud_div_i    : cycles per bit, 0 = CLK_FRQ/BAUD_RATE, 1 is clamped to 2
//   parity_mode_i : 00/11 none, 01 even, 10 odd (only with UART_TX_PARITY_EN)
//   tx_busy_o     : frame in progress
//   tx_out_o      : registered serial line, idles high
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRQ   = 27000000,
  parameter int unsigned BAUD_RATE = 921600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  logic [DIV_W-1:0]     baud_div_i,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]           parity_mode_i,
`endif
  output logic                 tx_busy_o,
  output logic                 tx_out_o
);

  localparam int unsigned DEF_DIV = CLK_FRQ / BAUD_RATE;
  localparam logic [3:0]  LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LastStop = 4'(STOP_BITS - 1);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DIV_W-1:0]     div_q;
  logic [3:0]           idx_q;     // data bit or stop bit index within the state
  logic                 tx_out_q;
  logic [DIV_W-1:0]     div_eff;
  logic                 bit_done;
  logic                 idle;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_bit_q;
  logic acc_par_en, acc_par_bit;

  // Parity is resolved from the word at acceptance so later input changes
  // cannot leak into the frame.
  assign acc_par_en  = (parity_mode_i == PAR_EVEN) || (parity_mode_i == PAR_ODD);
  assign acc_par_bit = (^tx_data_i) ^ (parity_mode_i == PAR_ODD);
`endif

  assign div_eff    = DIV_W'(eff_div(32'(baud_div_i), DEF_DIV));
  assign idle       = (state_q == StIdle);
  assign tx_ready_o = idle;
  assign tx_busy_o  = !idle;
  assign tx_out_o   = tx_out_q;

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (idle),
    .en_i       (!idle),
    .div_i      (div_q),
    .bit_done_o (bit_done)
  );

  // tx_out_q is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      tx_out_q  <= 1'b1;
      shreg_q   <= '0;
      div_q     <= '0;
      idx_q     <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_out_q <= 1'b1;
          idx_q    <= '0;
          if (tx_valid_i) begin
            state_q   <= StStart;
            tx_out_q  <= 1'b0;
            shreg_q   <= tx_data_i;
            div_q     <= div_eff;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= acc_par_en;
            par_bit_q <= acc_par_bit;
`endif
          end
        end
        StStart: begin
          if (bit_done) begin
            state_q  <= StData;
            tx_out_q <= shreg_q[0];
            idx_q    <= '0;
          end
        end
        StData: begin
          if (bit_done) begin
            shreg_q <= shreg_q >> 1;
            if (idx_q == LastData) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state_q  <= StParity;
                tx_out_q <= par_bit_q;
              end else
`endif
              begin
                state_q  <= StStop;
                tx_out_q <= 1'b1;
                idx_q    <= '0;
              end
            end else begin
              idx_q    <= idx_q + 4'd1;
              tx_out_q <= shreg_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bit_done) begin
            state_q  <= StStop;
            tx_out_q <= 1'b1;
            idx_q    <= '0;
          end
        end
`endif
        StStop: begin
          if (bit_done) begin
            if (idx_q == LastStop) begin
              state_q <= StIdle;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          tx_out_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame.
// Main instance uses 8 data bits / 1 stop bit; a second instance uses 5 data
// bits / 2 stop bits. Parity cases are compiled in with UART_TX_PARITY_EN.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] baud_div;
  logic        tx_busy;
  logic        tx_out;
`ifdef UART_TX_PARITY_EN
  logic [1:0]  parity_mode;
`endif

  logic [4:0]  u5_data;
  logic        u5_valid;
  logic        u5_ready;
  logic [15:0] u5_div;
  logic        u5_busy;
  logic        u5_out;

  int checks = 0;
  int errors = 0;

  logic cap [320];
  logic rdy [320];
  logic bsy [320];
  logic exp_bits [16];
  int   exp_len;
  logic [7:0] b2b_words [3];

  always #5 clk = ~clk;

  uart_tx_frame dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .baud_div_i    (baud_div),
`ifdef UART_TX_PARITY_EN
    .parity_mode_i (parity_mode),
`endif
    .tx_busy_o     (tx_busy),
    .tx_out_o      (tx_out)
  );

  uart_tx_frame #(
    .DATA_BITS (5),
    .STOP_BITS (2)
  ) dut5 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tx_data_i     (u5_data),
    .tx_valid_i    (u5_valid),
    .tx_ready_o    (u5_ready),
    .baud_div_i    (u5_div),
`ifdef UART_TX_PARITY_EN
    .parity_mode_i (2'b00),
`endif
    .tx_busy_o     (u5_busy),
    .tx_out_o      (u5_out)
  );

  // Reference frame: start, data LSB first, optional parity, stop bits.
  function automatic void build_frame(input logic [8:0] data, input int nbits,
                                      input logic [1:0] pmode, input int nstop);
    logic p;
    exp_len = 0;
    exp_bits[exp_len++] = 1'b0;
    p = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      exp_bits[exp_len++] = data[b];
      p = p ^ data[b];
    end
    if (pmode == 2'b01) exp_bits[exp_len++] = p;
    if (pmode == 2'b10) exp_bits[exp_len++] = ~p;
    for (int s = 0; s < nstop; s++) exp_bits[exp_len++] = 1'b1;
  endfunction

  // Offer one word on the main instance and record n cycles of outputs,
  // starting with the first cycle after the accepting edge.
  task automatic send_capture(input logic [7:0] data, input logic [15:0] div, input int n);
    @(negedge clk);
    tx_data  = data;
    baud_div = div;
    tx_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap[i] = tx_out;
      rdy[i] = tx_ready;
      bsy[i] = tx_busy;
      if (i == 0) tx_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold out/ready/busy got %b%b%b want 110", tx_out, tx_ready, tx_busy);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || u5_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle out/ready/busy/u5 got %b%b%b%b want 1101",
               tx_out, tx_ready, tx_busy, u5_out);
    end
  endtask

  task automatic test_8n1();
    int nlow;
    logic e;
    send_capture(8'h55, 16'd4, 44);
    build_frame(9'h055, 8, 2'b00, 1);
    for (int i = 0; i < 44; i++) begin
      e = (i < exp_len * 4) ? exp_bits[i / 4] : 1'b1;
      checks++;
      if (cap[i] !== e) begin
        errors++;
        $display("FAIL 8n1_55 cycle %0d tx_out got %b want %b", i, cap[i], e);
      end
    end
    nlow = 0;
    for (int i = 0; i < 44; i++) if (rdy[i] === 1'b0) nlow++;
    checks++;
    if (nlow != 40 || rdy[40] !== 1'b1) begin
      errors++;
      $display("FAIL 8n1_ready low cycles got %0d want 40 (rdy40=%b)", nlow, rdy[40]);
    end
    checks++;
    if (bsy[0] !== 1'b1 || bsy[40] !== 1'b0) begin
      errors++;
      $display("FAIL 8n1_busy got %b/%b want 1/0", bsy[0], bsy[40]);
    end
  endtask

  task automatic test_divisor();
    int nlow;
    logic e;
    // baud_div = 0 -> 27000000 / 921600 = 29 cycles per bit
    send_capture(8'hFF, 16'd0, 300);
    checks++;
    if (cap[0] !== 1'b0 || cap[28] !== 1'b0 || cap[29] !== 1'b1) begin
      errors++;
      $display("FAIL div0_start got %b%b%b want 001", cap[0], cap[28], cap[29]);
    end
    nlow = 0;
    for (int i = 0; i < 300; i++) if (rdy[i] === 1'b0) nlow++;
    checks++;
    if (nlow != 290 || rdy[290] !== 1'b1) begin
      errors++;
      $display("FAIL div0_frame ready low got %0d want 290", nlow);
    end
    // baud_div = 1 -> clamped to 2
    send_capture(8'hFE, 16'd1, 24);
    build_frame(9'h0FE, 8, 2'b00, 1);
    for (int i = 0; i < 24; i++) begin
      e = (i < exp_len * 2) ? exp_bits[i / 2] : 1'b1;
      checks++;
      if (cap[i] !== e) begin
        errors++;
        $display("FAIL div1_clamp cycle %0d tx_out got %b want %b", i, cap[i], e);
      end
    end
    checks++;
    if (rdy[19] !== 1'b0 || rdy[20] !== 1'b1) begin
      errors++;
      $display("FAIL div1_ready got %b%b want 01", rdy[19], rdy[20]);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [1:0] modes [4] = '{2'b01, 2'b10, 2'b01, 2'b11};
    logic [7:0] words [4] = '{8'h07, 8'h07, 8'h03, 8'h07};
    logic       pbits [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int         lens  [4] = '{22, 22, 22, 20};
    int nlow;
    logic e;
    for (int v = 0; v < 4; v++) begin
      parity_mode = modes[v];
      send_capture(words[v], 16'd2, 24);
      parity_mode = 2'b00;
      checks++;
      if (cap[18] !== pbits[v]) begin
        errors++;
        $display("FAIL parity_bit vec %0d got %b want %b", v, cap[18], pbits[v]);
      end
      build_frame({1'b0, words[v]}, 8, modes[v], 1);
      for (int i = 0; i < 24; i++) begin
        e = (i < exp_len * 2) ? exp_bits[i / 2] : 1'b1;
        checks++;
        if (cap[i] !== e) begin
          errors++;
          $display("FAIL parity_frame vec %0d cycle %0d got %b want %b", v, i, cap[i], e);
        end
      end
      nlow = 0;
      for (int i = 0; i < 24; i++) if (rdy[i] === 1'b0) nlow++;
      checks++;
      if (nlow != lens[v]) begin
        errors++;
        $display("FAIL parity_len vec %0d got %0d want %0d", v, nlow, lens[v]);
      end
    end
  endtask
`endif

  task automatic test_5n2();
    int nlow;
    logic e;
    @(negedge clk);
    u5_data  = 5'h1F;
    u5_div   = 16'd3;
    u5_valid = 1'b1;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      cap[i] = u5_out;
      rdy[i] = u5_ready;
      if (i == 0) u5_valid = 1'b0;
    end
    build_frame(9'h01F, 5, 2'b00, 2);
    for (int i = 0; i < 26; i++) begin
      e = (i < exp_len * 3) ? exp_bits[i / 3] : 1'b1;
      checks++;
      if (cap[i] !== e) begin
        errors++;
        $display("FAIL 5n2 cycle %0d tx_out got %b want %b", i, cap[i], e);
      end
    end
    nlow = 0;
    for (int i = 0; i < 26; i++) if (rdy[i] === 1'b0) nlow++;
    checks++;
    if (nlow != 24) begin
      errors++;
      $display("FAIL 5n2_len ready low got %0d want 24", nlow);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    int nlow;
    int f;
    int pos;
    logic prev_rdy;
    logic e;
    b2b_words[0] = 8'h3C;
    b2b_words[1] = 8'hA5;
    b2b_words[2] = 8'h81;
    @(negedge clk);
    baud_div = 16'd2;
    tx_data  = b2b_words[0];
    tx_valid = 1'b1;
    idx      = 0;
    prev_rdy = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      cap[i] = tx_out;
      rdy[i] = tx_ready;
      if (prev_rdy && !tx_ready) begin
        // Just accepted: scramble the inputs for the rest of the frame.
        idx++;
        tx_data  = ~b2b_words[idx - 1];
        baud_div = 16'd9;
        if (idx == 3) tx_valid = 1'b0;
      end else if (tx_ready && idx < 3) begin
        tx_data  = b2b_words[idx];
        baud_div = 16'd2;
      end
      prev_rdy = tx_ready;
    end
    tx_valid = 1'b0;
    checks++;
    if (idx != 3) begin
      errors++;
      $display("FAIL b2b_count accepted got %0d want 3", idx);
    end
    for (int i = 0; i < 70; i++) begin
      f   = i / 21;
      pos = i % 21;
      e   = 1'b1;
      if (f < 3 && pos < 20) begin
        build_frame({1'b0, b2b_words[f]}, 8, 2'b00, 1);
        e = exp_bits[pos / 2];
      end
      checks++;
      if (cap[i] !== e) begin
        errors++;
        $display("FAIL b2b cycle %0d tx_out got %b want %b", i, cap[i], e);
      end
    end
    nlow = 0;
    for (int i = 0; i < 70; i++) if (rdy[i] === 1'b0) nlow++;
    checks++;
    if (nlow != 60) begin
      errors++;
      $display("FAIL b2b_ready low cycles got %0d want 60", nlow);
    end
  endtask

  task automatic test_reset_mid();
    logic e;
    @(negedge clk);
    tx_data  = 8'h3C;
    baud_div = 16'd4;
    tx_valid = 1'b1;
    // Samples 16..19 carry data bit 3; stop inside it.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) tx_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async out/ready/busy got %b%b%b want 110", tx_out, tx_ready, tx_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (tx_out !== 1'b1 || tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_idle cycle %0d out/ready got %b%b want 11", i, tx_out, tx_ready);
      end
    end
    send_capture(8'hA5, 16'd4, 44);
    build_frame(9'h0A5, 8, 2'b00, 1);
    for (int i = 0; i < 44; i++) begin
      e = (i < exp_len * 4) ? exp_bits[i / 4] : 1'b1;
      checks++;
      if (cap[i] !== e) begin
        errors++;
        $display("FAIL rst_mid_a5 cycle %0d tx_out got %b want %b", i, cap[i], e);
      end
    end
  endtask

  initial begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    baud_div = 16'd4;
    u5_data  = 5'h00;
    u5_valid = 1'b0;
    u5_div   = 16'd3;
`ifdef UART_TX_PARITY_EN
    parity_mode = 2'b00;
`endif
    test_reset();
    test_8n1();
    test_divisor();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_5n2();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
